phase_acc: RTL and testbench
============================

# phase_acc

Phase accumulator feeding the N-bit phase word to the DDS waveform stages (saw, and any other waveform generators sharing the phase bus). It holds an N-bit frequency tuning word (FTW) and a phase offset, both written a byte at a time through a small register port into shadow registers. A commit pulse moves them into the active set, either immediately or at the next accumulator wrap for glitch-free frequency changes. Each enabled clock adds FTW to the accumulator; it outputs the offset-adjusted phase plus a wrap strobe.

## Interface
- N, 14: phase/FTW/offset width; legal range 9..16, so each value spans two bytes.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  advance enable; the accumulator steps only when high.
- clr  in  1  synchronous phase clear.
- wr_stb  in  1  one-cycle register write strobe.
- wr_addr  in  2  0 = FTW[7:0], 1 = FTW[N-1:8], 2 = OFF[7:0], 3 = OFF[N-1:8]; unused high bits of wr_data are ignored.
- wr_data  in  8  write data.
- upd  in  1  one-cycle commit request, shadow → active.
- sync_upd  in  1  commit mode: 0 = immediate, 1 = deferred to the next wrap.
- phase  out  N  registered phase; always equals (acc + off_act) mod 2^N.
- wrap  out  1  one-cycle pulse on the edge where the accumulator overflowed.
- upd_pending  out  1  high while a deferred commit is waiting.

## Operation
- State:
  - acc[N-1:0]
  - ftw_sh and ftw_act
  - off_sh and off_act
  - pending flag
  - phase and wrap registers
- Reset (async):
  - acc, ftw_sh, ftw_act, off_sh, off_act, phase, wrap, and upd_pending all go to 0.
- Shadow writes:
  - When wr_stb is high, the addressed byte of ftw_sh/off_sh loads at the edge.
  - Shadow writes never disturb the active values.
- Priority per edge: rst > clr > en.
- clr:
  - acc ← 0; wrap ← 0; phase ← off value valid after this edge.
  - Any pending or simultaneous upd commits on this edge, regardless of sync_upd; pending ← 0.
- en=1, clr=0:
  - {carry, acc} ← acc + ftw_act (N+1-bit sum).
  - wrap ← carry.
- en=0, clr=0:
  - acc holds; wrap ← 0.
- Commit with sync_upd=0:
  - upd → ftw_act ← ftw_sh, off_act ← off_sh at that edge.
  - The new FTW first affects the next increment.
  - phase reflects the new offset immediately after that edge.
- Commit with sync_upd=1:
  - upd sets pending.
  - The transfer happens on the first edge with en=1 and carry=1. This includes the same edge as upd if that edge carries.
  - pending clears on the transfer.
  - The old FTW is used for the wrapping add; the new FTW is used from the next add onward.
- Shadow writes while pending: the transfer uses the shadow value current at the transfer edge.
- upd while pending: no additional effect.
- sync_upd is sampled only on the upd cycle.
- ftw_act=0 with en=1: phase is static, no wrap occurs, and a deferred commit waits indefinitely; clr or an immediate upd resolves it.
- A write and an immediate upd on the same edge: upd commits the old shadow value; the write lands in the shadow only.

## Timing
- phase is registered: phase ← (acc_next + off_act_next) mod 2^N. There is zero extra latency relative to acc.
- wrap is asserted in the same cycle phase shows the wrapped value.
- FTW write → effect: one write edge, then an upd edge, then the first add using the new FTW on the following enabled edge.
- Throughput: one step per enabled clock.
- upd_pending is registered; it rises the edge after upd and falls on the transfer edge.
- Reset is asynchronous: outputs go to 0 immediately on rst assertion, and the first step occurs on the first enabled edge after deassertion.

## Test plan
- Reset and basic step (N=14):
  - Stimulus: write FTW=0x0100, upd with sync_upd=0, then en=1 for 64 cycles.
  - Required: phase counts 0x0100, 0x0200, …, reaches 0x0000 on step 64 with wrap=1 for exactly that cycle.
- Odd-FTW wrap:
  - Stimulus: FTW=0x3FFF.
  - Required: phase steps 0x3FFF, 0x3FFE (wrap=1), 0x3FFD (wrap=1), …
- Offset:
  - Stimulus: OFF=0x1000 committed immediately with acc=0x0200.
  - Required: phase=0x1200 the cycle after upd; acc is unchanged.
- Deferred commit:
  - Stimulus: FTW=0x0800 running, write FTW=0x0400, upd with sync_upd=1 at acc=0x1000.
  - Required: upd_pending=1 until the wrap edge (phase 0x0000); the next phases are 0x0400, 0x0800, …
- clr during pending:
  - Stimulus: as above, assert clr at acc=0x2000.
  - Required: phase=OFF, wrap=0, upd_pending=0, and the new FTW is used on the next step.
- Async reset mid-run:
  - Stimulus: pulse rst between edges.
  - Required: phase, wrap, and upd_pending go to 0 before the next edge, and stepping needs a new FTW write plus upd.

Source files
------------

// File: rtl/phase_acc.sv
// Phase accumulator for the DDS phase bus: byte-written FTW/offset shadows, immediate or wrap-synchronous commit.
// Latency: phase and wrap are registered and track acc on the same edge; one step per enabled clock, no backpressure.
module phase_acc #(
  parameter int N = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         wr_stb,
  input  logic [1:0]   wr_addr,
  input  logic [7:0]   wr_data,
  input  logic         upd,
  input  logic         sync_upd,
  output logic [N-1:0] phase,
  output logic         wrap,
  output logic         upd_pending
);

  logic [N-1:0] r_acc;
  logic [N-1:0] r_ftw_sh;
  logic [N-1:0] r_ftw_act;
  logic [N-1:0] r_off_sh;
  logic [N-1:0] r_off_act;
  logic [N-1:0] r_phase;
  logic         r_wrap;
  logic         r_pending;

  logic [N:0]   w_sum;
  logic         w_carry;
  logic         w_commit;
  logic         w_pending_nxt;
  logic [N-1:0] w_acc_nxt;
  logic [N-1:0] w_ftw_act_nxt;
  logic [N-1:0] w_off_act_nxt;

  assign w_sum   = {1'b0, r_acc} + {1'b0, r_ftw_act};
  assign w_carry = w_sum[N];

  // A deferred request (already pending, or arriving this cycle) transfers on a carrying add;
  // an immediate request transfers at once and also cancels anything pending.
  always_comb begin
    w_commit      = 1'b0;
    w_pending_nxt = r_pending;
    w_acc_nxt     = r_acc;
    if (clr) begin
      w_commit      = r_pending | upd;
      w_pending_nxt = 1'b0;
      w_acc_nxt     = '0;
    end else begin
      if (upd && !sync_upd) begin
        w_commit      = 1'b1;
        w_pending_nxt = 1'b0;
      end else if ((r_pending || upd) && en && w_carry) begin
        w_commit      = 1'b1;
        w_pending_nxt = 1'b0;
      end else if (upd) begin
        w_pending_nxt = 1'b1;
      end
      if (en) begin
        w_acc_nxt = w_sum[N-1:0];
      end
    end
  end

  assign w_ftw_act_nxt = w_commit ? r_ftw_sh : r_ftw_act;
  assign w_off_act_nxt = w_commit ? r_off_sh : r_off_act;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ftw_sh <= '0;
      r_off_sh <= '0;
    end else if (wr_stb) begin
      case (wr_addr)
        2'd0:    r_ftw_sh[7:0]   <= wr_data;
        2'd1:    r_ftw_sh[N-1:8] <= wr_data[N-9:0];
        2'd2:    r_off_sh[7:0]   <= wr_data;
        default: r_off_sh[N-1:8] <= wr_data[N-9:0];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc     <= '0;
      r_ftw_act <= '0;
      r_off_act <= '0;
      r_phase   <= '0;
      r_wrap    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_acc     <= w_acc_nxt;
      r_ftw_act <= w_ftw_act_nxt;
      r_off_act <= w_off_act_nxt;
      r_phase   <= w_acc_nxt + w_off_act_nxt;
      r_wrap    <= !clr && en && w_carry;
      r_pending <= w_pending_nxt;
    end
  end

  assign phase       = r_phase;
  assign wrap        = r_wrap;
  assign upd_pending = r_pending;

endmodule

// File: tb/tb_phase_acc.sv
// Directed self-checking bench for phase_acc (N=14) with hand-computed expected phase/wrap/pending values.
module tb_phase_acc;
  localparam int N = 14;

  logic         clk = 1'b0;
  logic         rst;
  logic         en, clr, wr_stb, upd, sync_upd;
  logic [1:0]   wr_addr;
  logic [7:0]   wr_data;
  logic [N-1:0] phase;
  logic         wrap, upd_pending;

  int checks = 0;
  int failures = 0;

  phase_acc #(.N(N)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .upd(upd), .sync_upd(sync_upd),
    .phase(phase), .wrap(wrap), .upd_pending(upd_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    wr_stb = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_stb = 1'b0;
  endtask

  task automatic commit(input logic s);
    upd = 1'b1; sync_upd = s;
    step();
    upd = 1'b0; sync_upd = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [N-1:0] ph, input logic w, input logic p);
    check({tag, ".phase"}, 32'(phase), 32'(ph));
    check({tag, ".wrap"}, 32'(wrap), 32'(w));
    check({tag, ".pend"}, 32'(upd_pending), 32'(p));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; wr_stb = 1'b0; upd = 1'b0; sync_upd = 1'b0;
    wr_addr = 2'd0; wr_data = 8'd0;
    #12;
    chk_out("reset", 14'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    step();

    // Basic step FTW=0x0100
    wr(2'd0, 8'h00); wr(2'd1, 8'h01); commit(1'b0);
    check("basic.idle", 32'(phase), 32'h0);
    en = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      step();
      check("basic.phase", 32'(phase), (i * 32'h100) & 32'h3FFF);
      check("basic.wrap", 32'(wrap), (i == 64) ? 32'd1 : 32'd0);
    end
    en = 1'b0;

    // Odd FTW 0x3FFF
    wr(2'd0, 8'hFF); wr(2'd1, 8'h3F); commit(1'b0);
    en = 1'b1;
    step(); chk_out("odd1", 14'h3FFF, 1'b0, 1'b0);
    step(); chk_out("odd2", 14'h3FFE, 1'b1, 1'b0);
    step(); chk_out("odd3", 14'h3FFD, 1'b1, 1'b0);
    step(); chk_out("odd4", 14'h3FFC, 1'b1, 1'b0);
    en = 1'b0;

    // Offset, immediate commit with acc=0x0200
    clr = 1'b1; step(); clr = 1'b0;
    chk_out("clr0", 14'h0000, 1'b0, 1'b0);
    wr(2'd0, 8'h00); wr(2'd1, 8'h02); commit(1'b0);
    en = 1'b1; step(); en = 1'b0;
    check("off.pre", 32'(phase), 32'h0200);
    wr(2'd2, 8'h00); wr(2'd3, 8'h10);
    check("off.shadow_only", 32'(phase), 32'h0200);
    commit(1'b0);
    check("off.commit", 32'(phase), 32'h1200);
    en = 1'b1; step(); en = 1'b0;
    check("off.step", 32'(phase), 32'h1400);
    wr(2'd3, 8'h00); commit(1'b0);
    check("off.clear", 32'(phase), 32'h0400);
    // write and immediate upd on the same edge: old shadow is committed
    wr_stb = 1'b1; wr_addr = 2'd3; wr_data = 8'h20; upd = 1'b1; sync_upd = 1'b0;
    step();
    wr_stb = 1'b0; upd = 1'b0;
    check("wrupd.same", 32'(phase), 32'h0400);
    commit(1'b0);
    check("wrupd.next", 32'(phase), 32'h2400);
    wr(2'd3, 8'h00); commit(1'b0);
    check("wrupd.revert", 32'(phase), 32'h0400);

    // Deferred commit
    clr = 1'b1; step(); clr = 1'b0;
    wr(2'd0, 8'h00); wr(2'd1, 8'h08); commit(1'b0);
    en = 1'b1;
    step(); check("def.a", 32'(phase), 32'h0800);
    step(); check("def.b", 32'(phase), 32'h1000);
    en = 1'b0;
    wr(2'd1, 8'h04);
    check("def.shadow_only", 32'(phase), 32'h1000);
    en = 1'b1; upd = 1'b1; sync_upd = 1'b1;
    step();
    upd = 1'b0; sync_upd = 1'b0;
    chk_out("def.upd", 14'h1800, 1'b0, 1'b1);
    step(); chk_out("def.2000", 14'h2000, 1'b0, 1'b1);
    step(); chk_out("def.2800", 14'h2800, 1'b0, 1'b1);
    step(); chk_out("def.3000", 14'h3000, 1'b0, 1'b1);
    step(); chk_out("def.3800", 14'h3800, 1'b0, 1'b1);
    step(); chk_out("def.wrap", 14'h0000, 1'b1, 1'b0);
    step(); chk_out("def.new1", 14'h0400, 1'b0, 1'b0);
    step(); chk_out("def.new2", 14'h0800, 1'b0, 1'b0);
    en = 1'b0;

    // clr during pending
    wr(2'd3, 8'h01); wr(2'd0, 8'h00); wr(2'd1, 8'h02);
    commit(1'b1);
    chk_out("clrp.upd", 14'h0800, 1'b0, 1'b1);
    en = 1'b1;
    for (int i = 1; i <= 6; i++) step();
    chk_out("clrp.2000", 14'h2000, 1'b0, 1'b1);
    clr = 1'b1; step(); clr = 1'b0;
    chk_out("clrp.clr", 14'h0100, 1'b0, 1'b0);
    step(); chk_out("clrp.next", 14'h0300, 1'b0, 1'b0);
    en = 1'b0;

    // Async reset mid-run
    commit(1'b1);
    check("arst.pre_pend", 32'(upd_pending), 32'd1);
    #2 rst = 1'b1;
    #1 chk_out("arst", 14'h0000, 1'b0, 1'b0);
    #1 rst = 1'b0;
    en = 1'b1;
    step(); check("arst.static", 32'(phase), 32'h0);
    wr(2'd0, 8'h00); wr(2'd1, 8'h01);
    check("arst.wr_only", 32'(phase), 32'h0);
    // zero FTW: a deferred commit never sees a carry
    commit(1'b1);
    chk_out("zero.pend", 14'h0000, 1'b0, 1'b1);
    step(); step(); step();
    chk_out("zero.wait", 14'h0000, 1'b0, 1'b1);
    commit(1'b0);
    chk_out("zero.imm", 14'h0000, 1'b0, 1'b0);
    step(); chk_out("zero.run", 14'h0100, 1'b0, 1'b0);
    en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
